game_flow_controller: RTL and testbench



---
 rtl/game_pkg.sv | 17 +
 rtl/game_flow_controller_speed_ramp.sv | 67 ++++++
 rtl/game_flow_controller.sv | 128 ++++++++++++
 tb/tb_game_flow_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types and width helpers for the Dino runner sequencer and renderers.
package game_pkg;

    typedef enum logic [1:0] {
        GS_IDLE    = 2'd0,
        GS_RUNNING = 2'd1,
        GS_CRASHED = 2'd2
    } game_state_t;

    // Integer part of speed and the width of the per-frame scroll step.
    localparam int SCROLL_W = 12;

    function automatic int speed_width(input int frac_bits);
        return SCROLL_W + frac_bits;
    endfunction

endpackage

// File: rtl/game_flow_controller_speed_ramp.sv
// Fixed-point scroll speed with a frame-count ramp and saturating cap; turns speed
// into integer per-frame scroll steps by carrying the fractional remainder forward.
module speed_ramp
    import game_pkg::*;
#(
    parameter int FRAC_PART_SIZE        = 2,
    parameter int SPEED_INCREASE_FRAMES = 600,
    parameter int START_SPEED           = 1,
    parameter int MAX_SPEED             = 12
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   load,
    input  logic                                   advance,
    output logic [SCROLL_W+FRAC_PART_SIZE-1:0]     speed,
    output logic [SCROLL_W-1:0]                    scroll_px,
    output logic                                   scroll_valid
);

    localparam int W     = speed_width(FRAC_PART_SIZE);
    localparam int TMR_W = (SPEED_INCREASE_FRAMES > 1) ? $clog2(SPEED_INCREASE_FRAMES) : 1;

    localparam logic [W-1:0] SPEED_START = W'(START_SPEED) << FRAC_PART_SIZE;
    localparam logic [W-1:0] SPEED_CAP   = W'(MAX_SPEED) << FRAC_PART_SIZE;

    logic [TMR_W-1:0]          ramp_tmr;
    logic [FRAC_PART_SIZE-1:0] frac;
    logic [W:0]                acc;
    logic                      ramp_step;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] s);
        return (s >= SPEED_CAP) ? SPEED_CAP : s + W'(1);
    endfunction

    // One extra bit so frac + speed never wraps before the integer part is taken.
    assign acc       = {1'b0, speed} + (W+1)'(frac);
    assign ramp_step = (ramp_tmr == TMR_W'(SPEED_INCREASE_FRAMES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed        <= SPEED_START;
            frac         <= '0;
            ramp_tmr     <= '0;
            scroll_px    <= '0;
            scroll_valid <= 1'b0;
        end else begin
            scroll_valid <= 1'b0;
            if (load) begin
                speed    <= SPEED_START;
                frac     <= '0;
                ramp_tmr <= '0;
            end else if (advance) begin
                // Scroll uses the pre-increment speed of this frame.
                scroll_px    <= SCROLL_W'(acc >> FRAC_PART_SIZE);
                frac         <= acc[FRAC_PART_SIZE-1:0];
                scroll_valid <= 1'b1;
                if (ramp_step) begin
                    ramp_tmr <= '0;
                    speed    <= sat_inc(speed);
                end else begin
                    ramp_tmr <= ramp_tmr + TMR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Dino runner game sequencer: IDLE/RUNNING/CRASHED flow, start-edge detection,
// score and hi-score tracking; speed and scroll generation live in speed_ramp.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int FRAC_PART_SIZE        = 2,
    parameter int SPEED_INCREASE_FRAMES = 600,
    parameter int START_SPEED           = 1,
    parameter int MAX_SPEED             = 12,
    parameter int CRASH_HOLD_FRAMES     = 120,
    parameter int SCORE_WIDTH           = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   frame_tick,
    input  logic                                   start_btn,
    input  logic                                   collision,
    output game_state_t                            state,
    output logic                                   game_active,
    output logic [SCROLL_W+FRAC_PART_SIZE-1:0]     speed,
    output logic [SCROLL_W-1:0]                    scroll_px,
    output logic                                   scroll_valid,
    output logic [SCORE_WIDTH-1:0]                 score,
    output logic [SCORE_WIDTH-1:0]                 hi_score
);

    localparam int HOLD_W = (CRASH_HOLD_FRAMES > 0) ? $clog2(CRASH_HOLD_FRAMES + 1) : 1;

    game_state_t       state_next;
    logic              start_q;
    logic              start_evt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic              ramp_load;
    logic              ramp_advance;
    logic              crash_evt;

    // The edge register tracks the button in every state, so a press held
    // through CRASHED cannot start a game when IDLE is re-entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q   <= 1'b0;
            start_evt <= 1'b0;
        end else begin
            start_q   <= start_btn;
            start_evt <= start_btn & ~start_q;
        end
    end

    assign hold_done = frame_tick && (hold_cnt <= HOLD_W'(1));

    always_comb begin
        state_next   = state;
        ramp_load    = 1'b0;
        ramp_advance = 1'b0;
        crash_evt    = 1'b0;
        case (state)
            GS_IDLE: begin
                if (start_evt) begin
                    state_next = GS_RUNNING;
                    ramp_load  = 1'b1;
                end
            end
            GS_RUNNING: begin
                if (collision) begin
                    state_next = GS_CRASHED;
                    crash_evt  = 1'b1;
                end else if (frame_tick) begin
                    ramp_advance = 1'b1;
                end
            end
            GS_CRASHED: begin
                if (hold_done) begin
                    state_next = GS_IDLE;
                end
            end
            default: state_next = GS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= GS_IDLE;
            game_active <= 1'b0;
        end else begin
            state       <= state_next;
            game_active <= (state_next == GS_RUNNING);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score    <= '0;
            hi_score <= '0;
            hold_cnt <= '0;
        end else begin
            if (ramp_load) begin
                score <= '0;
            end else if (ramp_advance && (score != '1)) begin
                score <= score + SCORE_WIDTH'(1);
            end
            if (crash_evt) begin
                hold_cnt <= HOLD_W'(CRASH_HOLD_FRAMES);
                if (score > hi_score) begin
                    hi_score <= score;
                end
            end else if ((state == GS_CRASHED) && frame_tick) begin
                hold_cnt <= hold_done ? '0 : hold_cnt - HOLD_W'(1);
            end
        end
    end

    speed_ramp #(
        .FRAC_PART_SIZE        (FRAC_PART_SIZE),
        .SPEED_INCREASE_FRAMES (SPEED_INCREASE_FRAMES),
        .START_SPEED           (START_SPEED),
        .MAX_SPEED             (MAX_SPEED)
    ) u_speed_ramp (
        .clk          (clk),
        .rst          (rst),
        .load         (ramp_load),
        .advance      (ramp_advance),
        .speed        (speed),
        .scroll_px    (scroll_px),
        .scroll_valid (scroll_valid)
    );

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller with a small reference model of the speed ramp.
module tb_game_flow_controller;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start_btn = 1'b0;
    logic        collision = 1'b0;
    game_state_t state;
    logic        game_active;
    logic [13:0] speed;
    logic [11:0] scroll_px;
    logic        scroll_valid;
    logic [15:0] score;
    logic [15:0] hi_score;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int m_speed, m_frac, m_timer, m_score, m_hi;

    game_flow_controller #(
        .FRAC_PART_SIZE        (2),
        .SPEED_INCREASE_FRAMES (2),
        .START_SPEED           (1),
        .MAX_SPEED             (2),
        .CRASH_HOLD_FRAMES     (3),
        .SCORE_WIDTH           (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .start_btn    (start_btn),
        .collision    (collision),
        .state        (state),
        .game_active  (game_active),
        .speed        (speed),
        .scroll_px    (scroll_px),
        .scroll_valid (scroll_valid),
        .score        (score),
        .hi_score     (hi_score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Every scroll_valid pulse must match the oldest expected step.
    always @(negedge clk) begin
        if (rst && scroll_valid) begin
            if (exp_q.size() == 0) chk("spurious_scroll_valid", 32'(scroll_valid), 32'd0);
            else                   chk("scroll_px", 32'(scroll_px), 32'(exp_q.pop_front()));
        end
    end

    task automatic do_tick(input bit col, input bit running);
        int acc;
        @(negedge clk);
        frame_tick = 1'b1;
        collision  = col;
        if (running && col) begin
            if (m_score > m_hi) m_hi = m_score;
        end else if (running) begin
            acc     = m_frac + m_speed;
            exp_q.push_back(acc >> 2);
            m_frac  = acc & 3;
            m_score = m_score + 1;
            if (m_timer == 1) begin
                m_timer = 0;
                if (m_speed < 8) m_speed = m_speed + 1;
            end else begin
                m_timer = m_timer + 1;
            end
        end
        @(negedge clk);
        frame_tick = 1'b0;
        collision  = 1'b0;
    endtask

    task automatic start_game();
        @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk);
        chk("start_edge_latency", 32'(state), 32'(GS_IDLE));
        @(negedge clk);
        chk("start_state", 32'(state), 32'(GS_RUNNING));
        chk("start_active", 32'(game_active), 32'd1);
        chk("start_speed", 32'(speed), 32'd4);
        chk("start_score", 32'(score), 32'd0);
        start_btn = 1'b0;
        m_speed = 4; m_frac = 0; m_timer = 0; m_score = 0;
    endtask

    task automatic crash_hold();
        for (int i = 1; i <= 3; i++) begin
            do_tick(1'b0, 1'b0);
            chk("hold_state", 32'(state), (i < 3) ? 32'(GS_CRASHED) : 32'(GS_IDLE));
            chk("hold_speed_frozen", 32'(speed), 32'(m_speed));
            chk("hold_score_frozen", 32'(score), 32'(m_score));
        end
    endtask

    initial begin
        m_speed = 4; m_frac = 0; m_timer = 0; m_score = 0; m_hi = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'(GS_IDLE));
        chk("rst_active", 32'(game_active), 32'd0);
        chk("rst_speed", 32'(speed), 32'd4);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_hi", 32'(hi_score), 32'd0);
        chk("rst_scroll_valid", 32'(scroll_valid), 32'd0);

        // Game 1: ramp through to the cap, then crash on a tick at score 10.
        start_game();
        for (int i = 1; i <= 10; i++) begin
            do_tick(1'b0, 1'b1);
            chk("run_speed", 32'(speed), 32'(m_speed));
            chk("run_score", 32'(score), 32'(m_score));
        end
        chk("speed_cap", 32'(speed), 32'd8);
        do_tick(1'b1, 1'b1);
        chk("crash_state", 32'(state), 32'(GS_CRASHED));
        chk("crash_active", 32'(game_active), 32'd0);
        chk("crash_score", 32'(score), 32'd10);
        chk("crash_hi", 32'(hi_score), 32'(m_hi));
        start_btn = 1'b1;
        crash_hold();
        repeat (4) @(negedge clk);
        chk("held_btn_stays_idle", 32'(state), 32'(GS_IDLE));
        start_btn = 1'b0;
        repeat (2) @(negedge clk);

        // Game 2: lower score must not displace the hi-score; collision without a tick.
        start_game();
        chk("game2_hi_kept", 32'(hi_score), 32'd10);
        for (int i = 1; i <= 5; i++) do_tick(1'b0, 1'b1);
        @(negedge clk);
        collision = 1'b1;
        if (m_score > m_hi) m_hi = m_score;
        @(negedge clk);
        collision = 1'b0;
        chk("game2_crash_state", 32'(state), 32'(GS_CRASHED));
        chk("game2_score", 32'(score), 32'd5);
        chk("game2_hi", 32'(hi_score), 32'(m_hi));
        crash_hold();

        // Game 3: asynchronous reset mid-run.
        start_game();
        for (int i = 1; i <= 3; i++) do_tick(1'b0, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'(GS_IDLE));
        chk("arst_active", 32'(game_active), 32'd0);
        chk("arst_speed", 32'(speed), 32'd4);
        chk("arst_score", 32'(score), 32'd0);
        chk("arst_hi", 32'(hi_score), 32'd0);
        chk("arst_scroll_px", 32'(scroll_px), 32'd0);
        chk("arst_scroll_valid", 32'(scroll_valid), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
